// File: rtl/my_dispatch_pkg.sv
// my_dispatch_pkg: shared constants and state encoding for the 8-way round-robin dispatcher
package my_dispatch_pkg;
    localparam int N_WAYS = 8;
    localparam int SEL_W = 3;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/my_rr_next_8.sv
// my_rr_next_8: first enabled index at or after start, wrapping 7->0
module my_rr_next_8
    import my_dispatch_pkg::*;
(
    input  logic [N_WAYS-1:0] mask,
    input  logic [SEL_W-1:0]  start,
    output logic [SEL_W-1:0]  sel,
    output logic              any_enabled
);
    always_comb begin
        sel = start;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            sel = mask[start + SEL_W'(i)] ? start + SEL_W'(i) : sel;
        end
    end
    assign any_enabled = |mask;
endmodule

// File: rtl/my_rr_dispatch_8_way.sv
// my_rr_dispatch_8_way: one-word holding register dispatched round-robin to 8 destinations
module my_rr_dispatch_8_way
    import my_dispatch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [N_WAYS-1:0] enable_mask,
    output logic [N_WAYS-1:0] out_valid,
    input  logic [N_WAYS-1:0] out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [SEL_W-1:0]  cur_sel
);
    state_t state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, scan_start, scan_sel;
    logic [WIDTH-1:0] data_q, data_d;
    logic any_en, accept, dispatch;
    assign dispatch = (state_q == FULL) & out_ready[sel_q];
    assign in_ready = ~reset & any_en & ((state_q == EMPTY) | dispatch);
    assign accept = in_valid & in_ready;
    // a word accepted in the dispatch cycle scans from just past the departing slot
    assign scan_start = dispatch ? sel_q + SEL_W'(1) : ptr_q;
    my_rr_next_8 u_next (
        .mask        (enable_mask),
        .start       (scan_start),
        .sel         (scan_sel),
        .any_enabled (any_en)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end
    always_comb begin
        state_d = accept ? FULL : (dispatch ? EMPTY : state_q);
        ptr_d   = dispatch ? sel_q + SEL_W'(1) : ptr_q;
        sel_d   = accept ? scan_sel : (dispatch ? '0 : sel_q);
        data_d  = accept ? in_data : data_q;
    end
    always_comb begin
        out_valid = (state_q == FULL) ? {{(N_WAYS-1){1'b0}}, 1'b1} << sel_q : '0;
        out_data  = data_q;
        cur_sel   = sel_q;
    end
endmodule

// File: doc/my_rr_dispatch_8_way.md
MY_RR_DISPATCH_8_WAY -- requirements
Module: my_rr_dispatch_8_way

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream word present.
REQ-005 Port: in_ready  output  1  block accepts the upstream word this cycle.
REQ-006 Port: in_data  input  WIDTH  upstream word.
REQ-007 Port: enable_mask  input  8  per-destination enable; bit k=1 means output k takes part in rotation.
REQ-008 Port: out_valid  output  8  one-hot valid for destination k; all-zero when nothing is held.
REQ-009 Port: out_ready  input  8  per-destination ready.
REQ-010 Port: out_data  output  WIDTH  held word, shared by all destinations.
REQ-011 Port: cur_sel  output  3  index of the latched destination; 0 when empty.

Function
REQ-012 The block SHALL hold one word in a holding register, with a two-state FSM: EMPTY and FULL.
REQ-013 Accept = in_valid & in_ready; dispatch = out_valid[cur_sel] & out_ready[cur_sel].
REQ-014 in_ready SHALL equal (enable_mask != 0) & (EMPTY | dispatch); it is combinational, and no path runs from in_valid to in_ready.
REQ-015 On accept, the block SHALL latch in_data and set cur_sel to the first enabled index at or after ptr, scanning upward and wrapping 7->0.
REQ-016 ptr SHALL be an internal 3-bit rotation pointer; on dispatch ptr <= cur_sel+1 mod 8 (7 wraps to 0).
REQ-017 On simultaneous dispatch and accept, the scan SHALL start from old cur_sel+1 mod 8; the block stays FULL with zero bubble, giving one word per cycle throughput.
REQ-018 FSM transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on dispatch without accept.
  - FULL -> FULL on dispatch with accept, or while waiting.
REQ-019 In FULL, out_valid SHALL be one-hot at cur_sel, and out_data and cur_sel SHALL stay stable until dispatch.
REQ-020 In FULL, out_valid SHALL NOT depend combinationally on out_ready.
REQ-021 Changes to enable_mask while FULL SHALL NOT alter the latched cur_sel; the word is delivered even if that bit is cleared.
REQ-022 With enable_mask == 0, no accept SHALL occur; a held word SHALL still be dispatched.
REQ-023 out_ready bits other than out_ready[cur_sel] SHALL be ignored.
REQ-024 Accept-to-out_valid latency SHALL be 1 cycle; there is no combinational path from in_data to out_data.

Reset
REQ-025 When reset is high at a clock edge, the block SHALL set: state EMPTY, ptr 0, cur_sel 0, out_valid 0, holding register 0.
REQ-026 Reset SHALL override a simultaneous accept or dispatch; a word held mid-operation is discarded.
REQ-027 in_ready SHALL be 0 while reset is asserted.

Structure
REQ-028 Package my_dispatch_pkg SHALL hold the constants N_WAYS=8 and SEL_W=3 and the state enum {EMPTY, FULL}.
REQ-029 Sub-module my_rr_next_8 SHALL be purely combinational, computing the first enabled index at or after a start index (wrap), plus an any_enabled flag; it is reused for both scan starts.

Verification
REQ-030 Reset check: mask=8'hFF, all out_ready=1, 10 back-to-back words -> destinations 0,1,...,7,0,1 in that order, one per cycle after the first, no bubbles.
REQ-031 Skip check: mask=8'b1010_0100, ready all 1, 4 words -> cur_sel 2,5,7,2.
REQ-032 Backpressure check: target 3 with out_ready[3]=0 for 5 cycles and other readies=1 -> out_valid=8'h08 held, out_data stable, in_ready=0 throughout; dispatch occurs in the cycle out_ready[3] rises.
REQ-033 Mask-change check: FULL at cur_sel=4, then clear mask bit 4 -> word still dispatched to 4; the next word goes to the next enabled index above 4.
REQ-034 Zero-mask check: mask=0 with in_valid=1 -> in_ready=0 and the held word drains; restoring mask=8'h01 -> next word goes to 0.
REQ-035 Reset mid-operation: FULL at cur_sel=6, then assert reset for 1 cycle -> out_valid=0, cur_sel=0; the next word goes to the first enabled index at or after 0.
